// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader that fills the sCPU instruction RAM and gates cpu_run
//
// Purpose: accepts a length byte L (1..16), then L instruction bytes, and
//          (optionally) an XOR checksum byte over a valid/ready stream. It
//          writes the instructions to RAM addresses 0..L-1 and releases the
//          CPU only after a complete, valid image has been loaded.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//          When defined, the stream ends with a checksum byte C = L ^ D0 ^ .. ^ D(L-1).
//          When undefined, the stream is L, D0..D(L-1) and there is no CSUM state.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle load request (honoured in IDLE, DONE, ERR)
//   in_valid   in   byte-stream valid
//   in_data    in   byte-stream data [7:0]
//   in_ready   out  loader accepts a byte this cycle (registered)
//   mem_we     out  instruction RAM write strobe (registered, 1-cycle pulse)
//   mem_addr   out  instruction RAM write address [3:0] (registered)
//   mem_wdata  out  instruction RAM write data [7:0] (registered)
//   cpu_run    out  CPU enable; high only after a successful load
//   done       out  last load succeeded
//   error      out  last load failed (sticky until the next start)

module program_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_run,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state;
    logic [4:0] len;
    logic [4:0] cnt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    logic accept;
    assign accept = in_valid && in_ready;

    // in_ready, done, error and cpu_run are all updated together with the
    // state so each is a registered function of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            len       <= 5'd0;
            cnt       <= 5'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 4'd0;
            mem_wdata <= 8'd0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LEN;
                        in_ready <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (in_data == 8'd0 || in_data > 8'd16) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA;
                            len   <= in_data[4:0];
                            cnt   <= 5'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            csum  <= in_data;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        // cnt never exceeds 15 while a byte is being written,
                        // so the low nibble is the full address.
                        mem_addr  <= cnt[3:0];
                        mem_wdata <= in_data;
                        cnt       <= cnt + 5'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum      <= csum ^ in_data;
                        if (cnt + 5'd1 == len) begin
                            state <= S_CSUM;
                        end
`else
                        if (cnt + 5'd1 == len) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_run  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_run  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Writer-side companion to the sCPU instruction memory: accepts a byte stream over a valid/ready handshake, writes a program of 1–16 eight-bit instructions into the 16×8 instruction RAM at addresses 0..N-1, and gates CPU execution until a complete, optionally checksummed, image has been loaded. Sits between the host-facing byte source and the instruction memory write port. `cpu_run` drives the CPU core's reset/enable path.

## Interface
- No parameters: address width 4 and data width 8 are fixed by the sCPU ISA.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  instruction RAM write strobe; registered.
- `mem_addr`  out  4  instruction RAM write address; registered.
- `mem_wdata`  out  8  instruction RAM write data; registered.
- `cpu_run`  out  1  high only after a successful load; CPU held in reset while low.
- `done`  out  1  level; the last load succeeded.
- `error`  out  1  level, sticky; the last load failed.

## Operation
- Byte transfer: a byte is accepted on an edge where `in_valid && in_ready`. `in_ready` is high only in LEN, DATA and CSUM.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE → LEN on `start`.
- LEN: accepts the length byte L.
  - L in 1..16: latch L, clear `cnt`, set `csum` = L, go to DATA.
  - L = 0 or L > 16: go to ERR.
- DATA: each accepted byte D is written to address `cnt`, `csum ^= D`, `cnt++`.
  - After byte number L, go to CSUM (macro on) or DONE (macro off).
- CSUM: accepts one byte.
  - Equal to `csum`: go to DONE.
  - Otherwise: go to ERR.
- DONE: `done`=1 and `cpu_run`=1.
- ERR: `error`=1 and `cpu_run`=0. RAM contents are undefined.
- Restart: `start` in DONE or ERR goes to LEN and clears `done`, `error` and `cpu_run` on that same edge.
- `start` while in LEN, DATA or CSUM is ignored.
- `cnt` is 5 bits wide, so L = 16 ends at `cnt` = 16. `mem_addr` never wraps past 15.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `cpu_run`, `done` and `error` all 0; `mem_addr` = 0, `mem_wdata` = 0, `cnt` = 0, `csum` = 0.
- Reset mid-load returns to IDLE immediately. Any partially written image is abandoned.
- Write latency: a data byte accepted on edge k appears on `mem_we`/`mem_addr`/`mem_wdata` for exactly the cycle after edge k. `mem_we` is a single-cycle pulse per byte.
- Throughput: one byte per cycle in LEN, DATA and CSUM when `in_valid` is held high. There are no bubbles.
- `in_ready` is a registered function of state. It drops in the cycle after the final byte is accepted.
- `done` and `cpu_run` rise on the edge that accepts the final byte: the checksum byte (macro on) or the last data byte (macro off).
- Because of the registered write, the final `mem_we` pulse coincides with the first cycle of `cpu_run`=1. The CPU samples instruction 0 only after its reset releases, so this is safe.
- `error` rises on the edge that accepts the offending byte.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - The stream is L, D0..D(L-1), C.
  - C must equal the XOR of L and all D bytes; otherwise the load ends in ERR.
- Not defined:
  - The stream is L, D0..D(L-1) only.
  - The CSUM state and `csum` register are removed.
  - DATA goes directly to DONE; ERR is reachable only via a bad length byte.

## Test plan
- Reset behaviour: assert `rst`=0 mid-DATA after 2 of 4 bytes → all outputs return to reset values within the same cycle. Then `start`, L=0x01, D=0x55, C=0x54 → single write 0x55 @0, `done`=1.
- Normal load (macro on): `start`, stream 0x03, 0x41, 0x52, 0x83, 0x93 at full rate → writes 0x41@0, 0x52@1, 0x83@2 on consecutive cycles; `done`=`cpu_run`=1; `error`=0.
- Bad checksum: same stream with C=0x92 → three writes occur, then `error`=1, `cpu_run`=0, `in_ready`=0. A following `start` clears `error` and `in_ready` reasserts.
- Length bounds:
  - L=0x00 → ERR, no `mem_we`.
  - L=0x11 → ERR, no `mem_we`.
  - L=0x10 with 16 bytes 0x00..0x0F and C=0x10 → addresses 0..15 written, last `mem_addr`=15, then DONE.
- Backpressure and ignored start: `in_valid` toggled every other cycle and `start` pulsed during DATA → writes occur only on accepted beats, the `start` has no effect, byte order is preserved.
- Macro off: `start`, stream 0x02, 0xAA, 0xBB → `done` rises on the 0xBB edge, and the next byte is not accepted (`in_ready`=0).
